// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchroniser, stable-level debounce FSM,
// and short/long press classification with registered one-cycle pulses.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic long_press,
  output logic short_press
);

  localparam int CNT_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } state_t;

  state_t state, state_n;

  logic              s0, s1;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [HOLD_W-1:0] hold, hold_n, hold_inc;
  logic              long_fired, long_fired_n;
  logic              level_n, short_n, long_n;
  logic              long_hit;

  always_ff @(posedge clk) begin
    if (rst) state <= RELEASED;
    else     state <= state_n;
  end

  // The FSM only ever looks at s1, never at the raw pad.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0          <= 1'b0;
      s1          <= 1'b0;
      cnt         <= '0;
      hold        <= '0;
      long_fired  <= 1'b0;
      btn_level   <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      s0          <= btn_in;
      s1          <= s0;
      cnt         <= cnt_n;
      hold        <= hold_n;
      long_fired  <= long_fired_n;
      btn_level   <= level_n;
      short_press <= short_n;
      long_press  <= long_n;
    end
  end

  assign hold_inc = (hold == HOLD_LAST) ? hold : hold + 1'b1;
  assign long_hit = ((state == PRESSED) || (state == RELEASE_PEND)) &&
                    (hold == HOLD_LAST) && !long_fired;

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    hold_n       = hold;
    long_fired_n = long_fired;
    level_n      = btn_level;
    short_n      = 1'b0;
    long_n       = 1'b0;
    case (state)
      RELEASED: begin
        if (s1) begin
          state_n = PRESS_PEND;
          cnt_n   = '0;
        end
      end
      PRESS_PEND: begin
        if (!s1) begin
          state_n = RELEASED;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n      = PRESSED;
          level_n      = 1'b1;
          cnt_n        = '0;
          hold_n       = '0;
          long_fired_n = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PRESSED: begin
        hold_n = hold_inc;
        if (!s1) begin
          state_n = RELEASE_PEND;
          cnt_n   = '0;
        end
      end
      RELEASE_PEND: begin
        // Hold time keeps accumulating so a release bounce does not restart it.
        hold_n = hold_inc;
        if (s1) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = RELEASED;
          level_n = 1'b0;
          cnt_n   = '0;
          short_n = !long_fired && !long_hit;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = RELEASED;
    endcase
    if (long_hit) begin
      long_n       = 1'b1;
      long_fired_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, LONG_CYCLES=20;
// expected levels and pulse edges are hand-computed per step.
module tb_button_debouncer;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic btn_level;
  logic long_press;
  logic short_press;

  int n_assert = 0;
  int n_fail   = 0;

  button_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .long_press (long_press),
    .short_press(short_press)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s@%0d observed=%b expected=%b", tag, idx, obs, exp);
    end
  endtask

  // Advance one edge, then sample all three outputs 1 ns later.
  task automatic tick_chk(input string ph, input int idx,
                          input logic el, input logic es, input logic elp);
    @(posedge clk);
    #1;
    chk({ph, ".level"}, idx, btn_level, el);
    chk({ph, ".short"}, idx, short_press, es);
    chk({ph, ".long"},  idx, long_press, elp);
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = 1'b0;
    tick_chk("reset", 0, 1'b0, 1'b0, 1'b0);
    tick_chk("reset", 1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 1; i <= 10; i++) tick_chk("idle", i, 1'b0, 1'b0, 1'b0);

    // Clean press then clean release: commit 7 edges after each change.
    btn_in = 1'b1;
    for (int e = 1; e <= 7; e++) tick_chk("press", e, e >= 7, 1'b0, 1'b0);
    btn_in = 1'b0;
    for (int e = 1; e <= 8; e++) tick_chk("release", e, e < 7, e == 7, 1'b0);

    // Bounce every 2 cycles: never commits.
    for (int c = 0; c < 20; c++) begin
      btn_in = ((c / 2) % 2) == 0;
      tick_chk("bounce", c, 1'b0, 1'b0, 1'b0);
    end
    btn_in = 1'b1;
    for (int e = 1; e <= 7; e++) tick_chk("settle", e, e >= 7, 1'b0, 1'b0);
    btn_in = 1'b0;
    for (int e = 1; e <= 8; e++) tick_chk("settle_rel", e, e < 7, e == 7, 1'b0);

    // Long hold: level at 7, long pulse at 7+20.
    btn_in = 1'b1;
    for (int e = 1; e <= 40; e++) tick_chk("long", e, e >= 7, 1'b0, e == 27);
    btn_in = 1'b0;
    for (int e = 1; e <= 8; e++) tick_chk("long_rel", e, e < 7, 1'b0, 1'b0);

    // Two-sample low glitch mid-hold: level holds, long pulse unchanged.
    for (int e = 1; e <= 30; e++) begin
      btn_in = !((e == 17) || (e == 18));
      tick_chk("glitch", e, e >= 7, 1'b0, e == 27);
    end
    btn_in = 1'b0;
    for (int e = 1; e <= 8; e++) tick_chk("glitch_rel", e, e < 7, 1'b0, 1'b0);

    // Reset while pressed: drop immediately, re-debounce from scratch.
    btn_in = 1'b1;
    for (int e = 1; e <= 10; e++) tick_chk("pre_rst", e, e >= 7, 1'b0, 1'b0);
    rst = 1'b1;
    tick_chk("rst_edge", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) tick_chk("post_rst", e, e >= 7, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
